instruction_fetch: RTL and testbench

Sequencer that sits directly downstream of the program addresser. It takes the 16-bit program counter the addresser produces and reads instruction bytes from program memory over a req/ack handshake. After each accepted byte it pulses the addresser's control strobes so the counter increments. Once the 1–3 byte instruction is assembled, it presents it to the decoder over a valid/ready handshake.

---
 rtl/mpp_pkg.sv | 26 ++
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instr_len_decode.sv | 10 +
 rtl/instruction_fetch.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpp_pkg.sv
// Shared fetch-path types: FSM state encoding, addresser strobe patterns and
// the opcode length decode used by the instruction fetch sequencer.
package mpp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        INCR,
        SETTLE,
        VALID
    } fetch_state_t;

    // bit1 = PCH clock, bit2 = PCL clock, bit0 = 0 selects increment
    localparam logic [4:0] PC_CTRL_IDLE = 5'b00000;
    localparam logic [4:0] PC_CTRL_INCR = 5'b00110;

    // Reserved class 2'b11 is treated as a single-byte opcode.
    function automatic logic [1:0] len_decode(input logic [1:0] opcode_hi);
        case (opcode_hi)
            2'b01:   return 2'd2;
            2'b10:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Program-memory req/ack bus plus the decoder valid/ready handshake.
// master = fetch sequencer, slave = memory/decoder side.
interface instruction_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_op1;
    logic [7:0]  instr_op2;
    logic [1:0]  instr_len;

    modport master (
        output mem_addr, mem_req, instr_valid, instr_opcode, instr_op1, instr_op2, instr_len,
        input  mem_ack, mem_data, instr_ready
    );

    modport slave (
        input  mem_addr, mem_req, instr_valid, instr_opcode, instr_op1, instr_op2, instr_len,
        output mem_ack, mem_data, instr_ready
    );
endinterface

// File: rtl/instr_len_decode.sv
// Combinational opcode-class to instruction-length decode (1..3 bytes).
// Zero latency, no handshake.
module instr_len_decode
    import mpp_pkg::*;
(
    input  logic [1:0] opcode_hi,
    output logic [1:0] len
);
    assign len = len_decode(opcode_hi);
endmodule

// File: rtl/instruction_fetch.sv
// Fetches 1-3 byte instructions over req/ack, strobing the PC addresser per byte; 3 cycles per zero-wait byte.
// Holds the assembled instruction in VALID until instr_ready. Optional REQ timeout: FETCH_TIMEOUT_EN.
module instruction_fetch
    import mpp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_en,
    input  logic                flush,
    input  logic [7:0]          pc_low,
    input  logic [7:0]          pc_high,
    output logic [4:0]          pc_ctrl,
    output logic                fetch_err,
    instruction_fetch_if.master bus
);

    fetch_state_t state, next_state;
    logic [1:0]   byte_idx;
    logic [1:0]   len_q;
    logic [1:0]   dec_len;
    logic [7:0]   opcode_q, op1_q, op2_q;
    logic [15:0]  addr_q;
    logic [15:0]  mem_addr;
    logic         mem_req;
    logic         instr_valid;
    logic         timeout_hit;
    logic         abort;

    instr_len_decode u_len_decode (
        .opcode_hi (bus.mem_data[7:6]),
        .len       (dec_len)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        mem_req     = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        pc_ctrl     = PC_CTRL_IDLE;
        unique case (state)
            IDLE: begin
                if (fetch_en) next_state = REQ;
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (bus.mem_ack)      next_state = INCR;
                else if (timeout_hit) next_state = IDLE;
            end
            INCR: begin
                pc_ctrl    = PC_CTRL_INCR;
                next_state = SETTLE;
            end
            SETTLE: begin
                next_state = (byte_idx == len_q - 2'd1) ? VALID : REQ;
            end
            VALID: begin
                instr_valid = 1'b1;
                if (bus.instr_ready) next_state = fetch_en ? REQ : IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Flush overrides everything, including an ack or ready in the same cycle.
        if (flush) next_state = IDLE;
    end

    assign abort = (state == REQ) && !bus.mem_ack && timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            byte_idx <= '0;
            len_q    <= '0;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            // PC is sampled on the edge entering REQ, i.e. after SETTLE lets the increment land.
            if (next_state == REQ && state != REQ) addr_q <= {pc_high, pc_low};

            if (flush || abort || (state == VALID && bus.instr_ready)) begin
                byte_idx <= '0;
                len_q    <= '0;
                opcode_q <= '0;
                op1_q    <= '0;
                op2_q    <= '0;
            end else if (state == REQ && bus.mem_ack) begin
                case (byte_idx)
                    2'd0: begin
                        opcode_q <= bus.mem_data;
                        len_q    <= dec_len;
                    end
                    2'd1:    op1_q <= bus.mem_data;
                    default: op2_q <= bus.mem_data;
                endcase
            end else if (state == SETTLE && next_state == REQ) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == REQ && next_state == REQ) begin
            to_cnt <= to_cnt + CW'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout_hit = (state == REQ) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign fetch_err   = timeout_hit && !bus.mem_ack && !flush;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign fetch_err          = 1'b0;
`endif

    assign bus.mem_req      = mem_req;
    assign bus.mem_addr     = mem_addr;
    assign bus.instr_valid  = instr_valid;
    assign bus.instr_opcode = opcode_q;
    assign bus.instr_op1    = op1_q;
    assign bus.instr_op2    = op2_q;
    assign bus.instr_len    = len_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench: memory responder, PC addresser model and decoder-side monitor around instruction_fetch.
module tb_instruction_fetch;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  pc_low, pc_high;
    logic [4:0]  pc_ctrl;
    logic        fetch_err;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] pc = 16'h0010;
    logic [7:0]  mem_img [0:255];
    int          wait_states = 0;
    bit          mem_en = 1'b1;
    int          resp_wcnt = 0;
    int          pulses = 0;
    int          strobe_viol = 0;
    logic [4:0]  prev_ctrl = 5'b00000;
    exp_t        sb[$];
    exp_t        mon_e;

    instruction_fetch_if bus();

    instruction_fetch #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .pc_low    (pc_low),
        .pc_high   (pc_high),
        .pc_ctrl   (pc_ctrl),
        .fetch_err (fetch_err),
        .bus       (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after wait_states idle REQ cycles.
    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (mem_en && bus.mem_req) begin
                if (resp_wcnt >= wait_states) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = mem_img[bus.mem_addr[7:0]];
                    check_eq("mem_addr", bus.mem_addr, pc);
                    resp_wcnt = 0;
                end else begin
                    resp_wcnt++;
                end
            end else begin
                resp_wcnt = 0;
            end
        end
    end

    // Edge-detecting program addresser: increments PC on each new 00110 strobe.
    initial begin
        {pc_high, pc_low} = pc;
        forever begin
            @(posedge clk); #1;
            if (pc_ctrl == 5'b00110) begin
                if (prev_ctrl == 5'b00110) strobe_viol++;
                else begin
                    pulses++;
                    pc = pc + 16'd1;
                end
            end else if (pc_ctrl != 5'b00000) begin
                strobe_viol++;
            end
            prev_ctrl = pc_ctrl;
            {pc_high, pc_low} = pc;
        end
    end

    // Decoder-side monitor: pops the scoreboard on every accepted instruction.
    initial forever begin
        @(negedge clk);
        if (bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                check_eq("sb_opcode", bus.instr_opcode, mon_e.op);
                check_eq("sb_op1", bus.instr_op1, mon_e.op1);
                check_eq("sb_op2", bus.instr_op2, mon_e.op2);
                check_eq("sb_len", bus.instr_len, mon_e.len);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // pre = idle negedges before REQ seen; lat = negedges from first REQ to instr_valid (-1 on timeout).
    task automatic measure_fetch(output int pre, output int lat);
        int n;
        bit seen;
        seen = 1'b0; n = 0; pre = 0; lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (seen) n++;
            else if (bus.mem_req) seen = 1'b1;
            else pre++;
            if (seen && bus.instr_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_one(input logic en);
        @(posedge clk); #1;
        bus.instr_ready = 1'b1;
        fetch_en = en;
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        int   pre, lat, p0, bad_stable, bad_req, req_n, err_n, err_at;
        exp_t snap;
        for (int i = 0; i < 256; i++) mem_img[i] = 8'h00;
        mem_img[8'h10] = 8'h05;
        mem_img[8'h11] = 8'h80;
        mem_img[8'h12] = 8'h34;
        mem_img[8'h13] = 8'h12;
        mem_img[8'h14] = 8'h41;
        mem_img[8'h15] = 8'hAB;
        mem_img[8'h16] = 8'h7F;
        mem_img[8'h17] = 8'hC3;
        bus.instr_ready = 1'b0;
        #1 reset = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", bus.instr_valid, 0);
        check_eq("rst_req", bus.mem_req, 0);
        check_eq("rst_addr", bus.mem_addr, 0);
        check_eq("rst_ctrl", pc_ctrl, 0);
        check_eq("rst_bytes", {bus.instr_opcode, bus.instr_op1, bus.instr_op2, bus.instr_len}, 0);
        check_eq("rst_err", fetch_err, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1-byte fetch, no wait states
        p0 = pulses;
        sb.push_back({8'h05, 8'h00, 8'h00, 2'd1});
        @(posedge clk); #1;
        fetch_en = 1'b1;
        measure_fetch(pre, lat);
        check_eq("t1_start", pre, 1);
        check_eq("t1_latency", lat, 3);
        check_eq("t1_pulses", pulses - p0, 1);
        release_one(1'b0);

        // 3-byte fetch, two wait states per byte
        wait_states = 2;
        p0 = pulses;
        sb.push_back({8'h80, 8'h34, 8'h12, 2'd3});
        fetch_en = 1'b1;
        measure_fetch(pre, lat);
        check_eq("t2_latency", lat, 15);
        check_eq("t2_pulses", pulses - p0, 3);
        check_eq("t2_pc", pc, 16'h0014);

        // Backpressure: hold in VALID for 5 cycles, then back-to-back 2-byte fetch
        snap = {bus.instr_opcode, bus.instr_op1, bus.instr_op2, bus.instr_len};
        bad_stable = 0;
        bad_req = 0;
        repeat (5) begin
            @(negedge clk);
            if (!bus.instr_valid ||
                {bus.instr_opcode, bus.instr_op1, bus.instr_op2, bus.instr_len} != snap)
                bad_stable++;
            if (bus.mem_req) bad_req++;
        end
        check_eq("bp_stable", bad_stable, 0);
        check_eq("bp_no_req", bad_req, 0);
        wait_states = 0;
        sb.push_back({8'h41, 8'hAB, 8'h00, 2'd2});
        release_one(1'b1);
        measure_fetch(pre, lat);
        check_eq("b2b_start", pre, 0);
        check_eq("t3_latency", lat, 6);

        // Flush during byte-1 REQ with a coincident ack
        release_one(1'b1);
        fetch_en = 1'b0;
        p0 = pulses;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check_eq("fl_setup", {bus.mem_req, bus.mem_ack}, 2'b11);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("fl_req_drop", bus.mem_req, 0);
        check_eq("fl_discard", bus.instr_opcode, 0);
        bad_req = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.instr_valid || bus.mem_req || pc_ctrl != 5'b00000) bad_req++;
        end
        check_eq("fl_quiet", bad_req, 0);
        check_eq("fl_pulses", pulses - p0, 1);
        check_eq("fl_pc", pc, 16'h0017);

        // Memory never answers
        mem_en = 1'b0;
        req_n = 0; err_n = 0; err_at = -1;
        @(posedge clk); #1;
        fetch_en = 1'b1;
        @(posedge clk); #1;
        fetch_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (8) begin
            @(negedge clk);
            if (bus.mem_req) req_n++;
            if (fetch_err) begin
                err_n++;
                err_at = req_n;
            end
        end
        check_eq("to_err_at", err_at, 4);
        check_eq("to_err_pulses", err_n, 1);
        check_eq("to_req_cycles", req_n, 4);
        check_eq("to_discard", bus.instr_opcode, 0);
`else
        repeat (40) begin
            @(negedge clk);
            if (bus.mem_req) req_n++;
            if (fetch_err) err_n++;
        end
        check_eq("nto_req_held", req_n, 40);
        check_eq("nto_no_err", err_n, 0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("nto_flush_idle", bus.mem_req, 0);
`endif
        mem_en = 1'b1;

        // Reserved-class opcode with one wait state, then async reset while VALID
        wait_states = 1;
        @(posedge clk); #1;
        fetch_en = 1'b1;
        measure_fetch(pre, lat);
        fetch_en = 1'b0;
        check_eq("t6_latency", lat, 4);
        check_eq("t6_opcode", bus.instr_opcode, 8'hC3);
        check_eq("t6_len", bus.instr_len, 1);
        check_eq("t6_op1", bus.instr_op1, 0);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_valid", bus.instr_valid, 0);
        check_eq("ar_bytes", {bus.instr_opcode, bus.instr_op1, bus.instr_op2, bus.instr_len}, 0);
        check_eq("ar_req", bus.mem_req, 0);
        check_eq("ar_ctrl", pc_ctrl, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle", {bus.mem_req, bus.instr_valid}, 0);

        check_eq("strobe_gaps", strobe_viol, 0);
        check_eq("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
